// File: rtl/ps2_scancode_xlat_if.sv
// ps2_scancode_xlat_if: FIFO-side and CPU-side signals of the scancode translator
interface ps2_scancode_xlat_if;
    logic [7:0] kbd_fifo_top;
    logic       kbd_rx_empty;
    logic       kbd_pop;
    logic       enable;
    logic       flush;
    logic       ack;
    logic [7:0] scan_code;
    logic       irq;

    modport master (
        output kbd_fifo_top, kbd_rx_empty, enable, flush, ack,
        input  kbd_pop, scan_code, irq
    );

    modport slave (
        input  kbd_fifo_top, kbd_rx_empty, enable, flush, ack,
        output kbd_pop, scan_code, irq
    );
endinterface

// File: rtl/ps2_scancode_xlat.sv
// ps2_scancode_xlat: pops PS/2 set-2 bytes and presents XT set-1 codes with a level IRQ1 request
module ps2_scancode_xlat #(
    parameter bit TRANSLATE = 1'b1
) (
    input  logic                 busclk,
    input  logic                 rst_n,
    ps2_scancode_xlat_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, POP, XLATE, HOLD} state_t;

    // Standard 8042 set-2 to set-1 table for bytes 00..7F
    localparam logic [6:0] SET1 [128] = '{
        7'h7f, 7'h43, 7'h41, 7'h3f, 7'h3d, 7'h3b, 7'h3c, 7'h58,
        7'h64, 7'h44, 7'h42, 7'h40, 7'h3e, 7'h0f, 7'h29, 7'h59,
        7'h65, 7'h38, 7'h2a, 7'h70, 7'h1d, 7'h10, 7'h02, 7'h5a,
        7'h66, 7'h71, 7'h2c, 7'h1f, 7'h1e, 7'h11, 7'h03, 7'h5b,
        7'h67, 7'h2e, 7'h2d, 7'h20, 7'h12, 7'h05, 7'h04, 7'h5c,
        7'h68, 7'h39, 7'h2f, 7'h21, 7'h14, 7'h13, 7'h06, 7'h5d,
        7'h69, 7'h31, 7'h30, 7'h23, 7'h22, 7'h15, 7'h07, 7'h5e,
        7'h6a, 7'h72, 7'h32, 7'h24, 7'h16, 7'h08, 7'h09, 7'h5f,
        7'h6b, 7'h33, 7'h25, 7'h17, 7'h18, 7'h0b, 7'h0a, 7'h60,
        7'h6c, 7'h34, 7'h35, 7'h26, 7'h27, 7'h19, 7'h0c, 7'h61,
        7'h6d, 7'h73, 7'h28, 7'h74, 7'h1a, 7'h0d, 7'h62, 7'h6e,
        7'h3a, 7'h36, 7'h1c, 7'h1b, 7'h75, 7'h2b, 7'h63, 7'h76,
        7'h55, 7'h56, 7'h77, 7'h78, 7'h79, 7'h7a, 7'h0e, 7'h7b,
        7'h7c, 7'h4f, 7'h7d, 7'h4b, 7'h47, 7'h7e, 7'h7f, 7'h6f,
        7'h52, 7'h53, 7'h50, 7'h4c, 7'h4d, 7'h48, 7'h01, 7'h45,
        7'h57, 7'h4e, 7'h51, 7'h4a, 7'h37, 7'h49, 7'h46, 7'h54
    };

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       brk_q, brk_d;
    logic       kbd_pop_q, kbd_pop_d;
    logic       irq_q, irq_d;
    logic [6:0] xlat;

    assign xlat          = (byte_q == 8'h83) ? 7'h41 : SET1[byte_q[6:0]];
    assign bus.kbd_pop   = kbd_pop_q;
    assign bus.irq       = irq_q;
    assign bus.scan_code = scan_code_q;

    // Next-state logic: fetch, translate, hold until ack; flush overrides everything
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        scan_code_d = scan_code_q;
        brk_d       = brk_q;
        irq_d       = irq_q;
        kbd_pop_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.enable && !bus.kbd_rx_empty) begin
                byte_d    = bus.kbd_fifo_top;
                kbd_pop_d = 1'b1;
                state_d   = POP;
            end
            POP: state_d = XLATE;
            XLATE: begin
                state_d     = HOLD;
                irq_d       = 1'b1;
                scan_code_d = byte_q;
                if (TRANSLATE) begin
                    if (byte_q == 8'hF0) begin
                        brk_d       = 1'b1;
                        state_d     = IDLE;
                        irq_d       = 1'b0;
                        scan_code_d = scan_code_q;
                    end else if (byte_q != 8'hE0 && byte_q != 8'hE1) begin
                        brk_d       = 1'b0;
                        scan_code_d = (!byte_q[7] || byte_q == 8'h83) ? {brk_q, xlat} : byte_q;
                    end
                end
            end
            HOLD: if (bus.ack) begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (bus.flush) begin
            state_d     = IDLE;
            irq_d       = 1'b0;
            brk_d       = 1'b0;
            kbd_pop_d   = 1'b0;
            scan_code_d = scan_code_q;
        end
    end

    // State and output registers
    always_ff @(posedge busclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= 8'h00;
            scan_code_q <= 8'h00;
            brk_q       <= 1'b0;
            kbd_pop_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            scan_code_q <= scan_code_d;
            brk_q       <= brk_d;
            kbd_pop_q   <= kbd_pop_d;
            irq_q       <= irq_d;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_xlat.sv
// tb_ps2_scancode_xlat: vector table, corner sequences and randomized stream against a rule-based model
module tb_ps2_scancode_xlat;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] b;
        logic       pre_f0;
        logic [7:0] exp;
    } vec_t;

    logic busclk = 1'b0;
    logic rst_n  = 1'b0;
    ps2_scancode_xlat_if bus();
    ps2_scancode_xlat #(.TRANSLATE(1'b1)) dut (.busclk(busclk), .rst_n(rst_n), .bus(bus.slave));

    always #5 busclk = ~busclk;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [7:0] fifo[$];
    logic [7:0] expq[$];
    logic       mbrk;
    logic [7:0] set1 [128] = '{
        8'h7f, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58,
        8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a,
        8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
        8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c,
        8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e,
        8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
        8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60,
        8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
        8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e,
        8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b,
        8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
        8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45,
        8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic refresh();
        bus.kbd_rx_empty = (fifo.size() == 0);
        bus.kbd_fifo_top = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    // One clock: the FIFO model consumes a byte if kbd_pop was high during the cycle
    task automatic step();
        logic p;
        p = bus.kbd_pop;
        @(posedge busclk);
        #1;
        if (p) begin
            pops++;
            check("pop_nonempty", fifo.size() != 0, 1);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        bus.ack   = 1'b0;
        bus.flush = 1'b0;
        refresh();
        if (bus.irq) check("no_pop_while_irq", bus.kbd_pop, 0);
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 60 && !bus.irq; i++) step();
        if (!bus.irq) check("irq_timeout", bus.irq, 1);
    endtask

    task automatic drain(input bq_t e, input string name);
        for (int i = 0; i < e.size(); i++) begin
            wait_irq();
            check(name, bus.scan_code, e[i]);
            bus.ack = 1'b1;
            step();
        end
        for (int i = 0; i < 8; i++) step();
        check({name, "_no_extra_irq"}, bus.irq, 0);
        check({name, "_fifo_empty"}, fifo.size(), 0);
    endtask

    task automatic run_seq(input bq_t b, input bq_t e, input string name);
        int p0;
        p0 = pops;
        foreach (b[i]) push(b[i]);
        drain(e, name);
        check({name, "_pops"}, pops - p0, b.size());
    endtask

    // Reference: set-1 code expected for each set-2 byte, from the translation rules
    task automatic model(input logic [7:0] b);
        if (b == 8'hF0) mbrk = 1'b1;
        else if (b == 8'hE0 || b == 8'hE1) expq.push_back(b);
        else if (b < 8'h80 || b == 8'h83) begin
            expq.push_back((b == 8'h83 ? 8'h41 : set1[b[6:0]]) + (mbrk ? 8'h80 : 8'h00));
            mbrk = 1'b0;
        end else begin
            expq.push_back(b);
            mbrk = 1'b0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        bus.enable = 1'b1;
        bus.ack    = 1'b0;
        bus.flush  = 1'b0;
        refresh();
        vecs = '{
            '{8'h1C, 1'b0, 8'h1E}, '{8'h1C, 1'b1, 8'h9E}, '{8'h12, 1'b0, 8'h2A},
            '{8'h7C, 1'b0, 8'h37}, '{8'h14, 1'b0, 8'h1D}, '{8'h77, 1'b0, 8'h45},
            '{8'h75, 1'b1, 8'hC8}, '{8'h83, 1'b0, 8'h41}, '{8'h83, 1'b1, 8'hC1},
            '{8'hAA, 1'b0, 8'hAA}, '{8'hFA, 1'b0, 8'hFA}, '{8'hAA, 1'b1, 8'hAA},
            '{8'h00, 1'b0, 8'h7F}, '{8'h7E, 1'b1, 8'hC6}
        };

        step();
        step();
        check("rst_irq", bus.irq, 0);
        check("rst_pop", bus.kbd_pop, 0);
        check("rst_code", bus.scan_code, 8'h00);
        rst_n = 1'b1;
        step();

        push(8'h1C);
        step();
        check("t1_pop_pulse", bus.kbd_pop, 1);
        step();
        check("t1_pop_once", bus.kbd_pop, 0);
        check("t1_irq_not_yet", bus.irq, 0);
        step();
        check("t1_irq", bus.irq, 1);
        check("t1_code", bus.scan_code, 8'h1E);
        for (int i = 0; i < 4; i++) step();
        check("t1_irq_held", bus.irq, 1);
        check("t1_pops", pops, 1);
        bus.ack = 1'b1;
        step();
        check("t1_irq_cleared", bus.irq, 0);

        foreach (vecs[i]) begin
            int p0;
            p0 = pops;
            if (vecs[i].pre_f0) push(8'hF0);
            push(vecs[i].b);
            wait_irq();
            check($sformatf("vec%0d_code", i), bus.scan_code, vecs[i].exp);
            bus.ack = 1'b1;
            step();
            for (int k = 0; k < 6; k++) step();
            check($sformatf("vec%0d_pops", i), pops - p0, vecs[i].pre_f0 ? 2 : 1);
        end

        run_seq('{8'hF0, 8'h1C, 8'h1C}, '{8'h9E, 8'h1E}, "t2");
        run_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, '{8'hE0, 8'h48, 8'hE0, 8'hC8}, "t3");
        run_seq('{8'hE0, 8'h12, 8'hE0, 8'h7C}, '{8'hE0, 8'h2A, 8'hE0, 8'h37}, "prtsc");
        run_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77},
                '{8'hE1, 8'h1D, 8'h45, 8'hE1, 8'h9D, 8'hC5}, "pause");

        push(8'h1C);
        wait_irq();
        begin
            int p0;
            p0 = pops;
            push(8'h15);
            push(8'h1D);
            push(8'h24);
            for (int i = 0; i < 10; i++) step();
            check("t5_no_pop_in_hold", pops - p0, 0);
            check("t5_irq_held", bus.irq, 1);
            check("t5_code", bus.scan_code, 8'h1E);
            bus.ack = 1'b1;
            step();
            drain('{8'h10, 8'h11, 8'h12}, "t5_drain");
        end

        bus.enable = 1'b0;
        begin
            int p0;
            p0 = pops;
            push(8'h1C);
            for (int i = 0; i < 8; i++) step();
            check("en_no_pop", pops - p0, 0);
            check("en_no_irq", bus.irq, 0);
        end
        bus.enable = 1'b1;
        drain('{8'h1E}, "en_resume");

        push(8'hF0);
        push(8'h1C);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #2;
        check("t6_rst_irq", bus.irq, 0);
        check("t6_rst_code", bus.scan_code, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t6_rst_no_irq", bus.irq, 0);
        run_seq('{8'h1C}, '{8'h1E}, "t6_after_rst");

        push(8'hF0);
        push(8'hE0);
        wait_irq();
        check("t6_hold_code", bus.scan_code, 8'hE0);
        bus.flush = 1'b1;
        bus.ack   = 1'b1;
        step();
        check("t6_flush_irq", bus.irq, 0);
        check("t6_flush_code", bus.scan_code, 8'hE0);
        for (int i = 0; i < 4; i++) step();
        run_seq('{8'h1C}, '{8'h1E}, "t6_after_flush");

        mbrk = 1'b0;
        expq.delete();
        for (int i = 0; i < 80; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hF0;
                2:       b = 8'hE0;
                3:       b = 8'hE1;
                4:       b = 8'h83;
                5:       b = 8'hAA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            push(b);
            model(b);
        end
        for (int cyc = 0; cyc < 3000 && (expq.size() != 0 || fifo.size() != 0); cyc++) begin
            if (bus.irq) begin
                if (expq.size() != 0) check("rand_code", bus.scan_code, expq.pop_front());
                else check("rand_extra_irq", bus.irq, 0);
                for (int k = $urandom_range(0, 2); k > 0; k--) step();
                bus.ack = 1'b1;
            end
            step();
        end
        for (int i = 0; i < 8; i++) step();
        check("rand_all_codes", expq.size(), 0);
        check("rand_fifo_empty", fifo.size(), 0);
        check("rand_no_irq", bus.irq, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
